switch_event_scheduler: RTL and testbench
=========================================

Name: switch_event_scheduler

Overview:
- Debounces N_SW raw board switches with one shared sample-tick prescaler and per-switch stable-sample counters.
- Converts each debounced transition into a press/release event.
- Serialises events from all switches onto one valid/ready event channel using a round-robin arbiter.
- Sits between the board switch pins and the game/control FSM. That FSM consumes events instead of polling per-switch debouncers.

Parameters:
- N_SW, 4, number of switch inputs (2..16).
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- SAMPLE_US, 1000, sample tick period in microseconds.
- STABLE_SAMPLES, 10, consecutive mismatching samples needed to accept a new level (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_Switch  in  N_SW  raw asynchronous switch levels, 1 = pressed.
- o_State  out  N_SW  debounced levels.
- o_Evt_Valid  out  1  event offered.
- i_Evt_Ready  in  1  consumer accepts event when high with o_Evt_Valid.
- o_Evt_Id  out  CLOG2(N_SW)  index of switch that changed.
- o_Evt_Press  out  1  1 = became pressed, 0 = became released.
- o_Overrun  out  1  one-cycle pulse: an undelivered event was cancelled.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state: every register is 0, including the synchronisers, prescaler, counters, pending/dir bits, RR pointer, FSM (IDLE) and all outputs. The reset assertion takes effect immediately, including mid-offer.
- Synchronisers: two flops per switch. All logic below uses the synchronised level s[i].
- Prescaler:
  - TICK_DIV = CLK_HZ/1_000_000*SAMPLE_US, must be ≥2; elaboration error otherwise.
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for the one cycle where count == TICK_DIV-1.
- Per-switch lane, evaluated only on tick (counters hold between ticks):
  - s[i] == o_State[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == STABLE_SAMPLES-1: o_State[i] <= s[i], cnt[i] <= 0, and raise a one-cycle change strobe with the new level.
  - Otherwise cnt[i] <= cnt[i]+1.
  - cnt width is CLOG2(STABLE_SAMPLES); it never exceeds STABLE_SAMPLES-1.
- Pending register (pending[i], dir[i]):
  - Strobe with pending[i] == 0: pending[i] <= 1, dir[i] <= new level.
  - Strobe with pending[i] == 1: the two opposite transitions cancel. pending[i] <= 0 and o_Overrun pulses for 1 cycle.
  - Strobe for the switch being granted in the same cycle: the grant clears that bit first, so the strobe sets pending normally, with no overrun.
- Arbiter FSM, state IDLE:
  - If any pending bit is set, select the first set index searching upward from ptr with wrap.
  - Register o_Evt_Id and o_Evt_Press = dir[sel], clear pending[sel], set o_Evt_Valid = 1, go to OFFER.
  - Valid therefore rises 1 cycle after the pending bit becomes visible.
- Arbiter FSM, state OFFER:
  - Id and Press stay stable and Valid stays high until i_Evt_Ready.
  - On Valid & Ready: o_Evt_Valid <= 0, ptr <= (Id+1) mod N_SW, go to IDLE.
  - Maximum throughput is 1 event per 2 cycles.
- Ready while in IDLE is ignored. Valid never drops without a handshake, except on reset.
- Worst-case latency from raw change to o_State: 2 + STABLE_SAMPLES*TICK_DIV cycles.

Decomposition:
- Shared package switch_pkg holds:
  - the CLOG2 function;
  - FSM state encodings, ST_IDLE = 0 and ST_OFFER = 1;
  - the TICK_DIV derivation function.
- Sub-module switch_debounce_lane contains the synchroniser, counter, o_State bit and change strobe. It takes tick as an input and is instantiated N_SW times.
- Prescaler, pending register and arbiter live in the top level.

Test Plan:
Bench parameters: CLK_HZ=1_000_000, SAMPLE_US=4 (TICK_DIV=4), STABLE_SAMPLES=3, N_SW=4.
- Reset: rst_n low for 10 cycles while toggling i_Switch -> all outputs 0. Release with i_Switch = 0, run 100 cycles -> no Valid, no Overrun.
- Clean press: i_Switch[2] = 1 held, Ready = 1 -> o_State[2] rises ≤14 cycles later. One event Id=2, Press=1, Valid high exactly 1 cycle. Then release -> one event Id=2, Press=0.
- Bounce: i_Switch[1] toggles every 5 cycles for 60 cycles, then stays 0 -> o_State[1] stays 0 and no events.
- Arbitration: press sw0, sw1, sw3 in the same cycle, Ready = 0 for 20 cycles -> Valid held with Id=0, Press=1 stable. Ready = 1 -> Ids 0, 1, 3 in order, one idle cycle between them. Then press sw0 and sw3 together -> order 0, 3 (ptr=0 after Id 3).
- Overrun: hold Ready = 0 while the sw0 event is offered; debounce a sw2 press, then a sw2 release -> o_Overrun 1-cycle pulse, pending[2] cleared. After Ready = 1 only the sw0 event appears; o_State[2] = 0.
- Async reset mid-offer: drop rst_n while Valid = 1, between clock edges -> Valid, Id and o_State go 0 immediately. After release, no stale event is emitted.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch event scheduler: arbiter states and
// elaboration-time helpers for counter widths and the sample-tick divider.
package switch_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int tick_div(input int clk_hz, input int sample_us);
        return clk_hz / 1_000_000 * sample_us;
    endfunction

endpackage

// File: rtl/switch_debounce_lane.sv
// One switch: two-flop synchroniser, stable-sample counter advanced on tick,
// debounced level and a one-cycle strobe whenever that level changes.
module switch_debounce_lane
    import switch_pkg::*;
#(
    parameter int STABLE_SAMPLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic state,
    output logic strobe
);
    localparam int CW = clog2(STABLE_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            state  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            strobe <= 1'b0;
            if (tick) begin
                if (sync_2 == state) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    state  <= sync_2;
                    cnt    <= '0;
                    strobe <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/switch_event_scheduler.sv
// Debounces N_SW switches and serialises their press/release events onto a
// single valid/ready channel through a round-robin arbiter.
module switch_event_scheduler
    import switch_pkg::*;
#(
    parameter int N_SW           = 4,
    parameter int CLK_HZ         = 25_000_000,
    parameter int SAMPLE_US      = 1000,
    parameter int STABLE_SAMPLES = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SW-1:0]          i_Switch,
    output logic [N_SW-1:0]          o_State,
    output logic                     o_Evt_Valid,
    input  logic                     i_Evt_Ready,
    output logic [clog2(N_SW)-1:0]   o_Evt_Id,
    output logic                     o_Evt_Press,
    output logic                     o_Overrun
);
    localparam int TICK_DIV = tick_div(CLK_HZ, SAMPLE_US);
    localparam int ID_W     = clog2(N_SW);
    localparam int PW       = clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ID_W:0]   N_SW_W     = (ID_W + 1)'(N_SW);
    localparam logic [ID_W-1:0] ID_LAST    = ID_W'(N_SW - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if (N_SW < 2 || N_SW > 16) begin : g_bad_n_sw
        $error("N_SW must be within 2..16");
    end
    if (STABLE_SAMPLES < 2) begin : g_bad_stable
        $error("STABLE_SAMPLES must be at least 2");
    end

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc <= '0;
        else        presc <= tick ? '0 : presc + 1'b1;
    end

    logic [N_SW-1:0] strobe;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_lane
        switch_debounce_lane #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (i_Switch[gi]),
            .state (o_State[gi]),
            .strobe(strobe[gi])
        );
    end

    arb_state_t        state_reg, state_next;
    logic [N_SW-1:0]   pending, pending_next;
    logic [N_SW-1:0]   dir, dir_next;
    logic [ID_W-1:0]   ptr, ptr_next;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   sel_off;
    logic [ID_W:0]     sel_sum;
    logic [2*N_SW-1:0] pending_rot;
    logic              grant;
    logic              valid_next;
    logic [ID_W-1:0]   id_next;
    logic              press_next;
    logic              overrun_next;

    // Rotate pending so bit 0 is the ptr slot, take the lowest set bit, then
    // map the offset back to a switch index modulo N_SW.
    always_comb begin
        pending_rot = {pending, pending} >> ptr;
        sel_off     = '0;
        for (int j = N_SW - 1; j >= 0; j--) begin
            if (pending_rot[j]) sel_off = ID_W'(j);
        end
        sel_sum = {1'b0, ptr} + {1'b0, sel_off};
        if (sel_sum >= N_SW_W) sel_sum = sel_sum - N_SW_W;
        sel = sel_sum[ID_W-1:0];
    end

    always_comb begin
        state_next = state_reg;
        valid_next = o_Evt_Valid;
        id_next    = o_Evt_Id;
        press_next = o_Evt_Press;
        ptr_next   = ptr;
        grant      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|pending) begin
                    grant      = 1'b1;
                    id_next    = sel;
                    press_next = dir[sel];
                    valid_next = 1'b1;
                    state_next = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (i_Evt_Ready) begin
                    valid_next = 1'b0;
                    ptr_next   = (o_Evt_Id == ID_LAST) ? '0 : o_Evt_Id + 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The grant clears its bit before strobes are applied, so a strobe on the
    // switch just granted starts a fresh event rather than cancelling.
    always_comb begin
        pending_next = pending;
        dir_next     = dir;
        overrun_next = 1'b0;
        if (grant) pending_next[sel] = 1'b0;
        for (int i = 0; i < N_SW; i++) begin
            if (strobe[i]) begin
                if (pending_next[i]) begin
                    pending_next[i] = 1'b0;
                    overrun_next    = 1'b1;
                end else begin
                    pending_next[i] = 1'b1;
                    dir_next[i]     = o_State[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pending     <= '0;
            dir         <= '0;
            ptr         <= '0;
            o_Evt_Valid <= 1'b0;
            o_Evt_Id    <= '0;
            o_Evt_Press <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending     <= pending_next;
            dir         <= dir_next;
            ptr         <= ptr_next;
            o_Evt_Valid <= valid_next;
            o_Evt_Id    <= id_next;
            o_Evt_Press <= press_next;
            o_Overrun   <= overrun_next;
        end
    end

endmodule

// File: tb/tb_switch_event_scheduler.sv
// Bench for switch_event_scheduler: directed scenarios plus randomized
// round-robin rounds checked against an event-level reference model.
module tb_switch_event_scheduler;
    localparam int N_SW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0;
    logic [3:0] state;
    logic       valid;
    logic       ready = 1'b0;
    logic [1:0] id;
    logic       press;
    logic       overrun;

    switch_event_scheduler #(
        .N_SW(N_SW), .CLK_HZ(1_000_000), .SAMPLE_US(4), .STABLE_SAMPLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_Switch(sw), .o_State(state),
        .o_Evt_Valid(valid), .i_Evt_Ready(ready), .o_Evt_Id(id),
        .o_Evt_Press(press), .o_Overrun(overrun)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // observation record filled by run_cycles
    int   acc_id[$];
    int   acc_press[$];
    int   acc_cyc[$];
    int   valid_cycles, ovr_cycles, stab_err, cyc;
    logic [3:0] st_hi;
    logic prev_valid = 1'b0, prev_acc = 1'b0, prev_press = 1'b0;
    logic [1:0] prev_id = '0;

    // reference model: current switch levels, round-robin start, expected events
    int         model_ptr = 0;
    logic [3:0] model_level = '0;
    int         exp_id[$];
    int         exp_press[$];

    task automatic clear_obs();
        acc_id.delete(); acc_press.delete(); acc_cyc.delete();
        valid_cycles = 0; ovr_cycles = 0; stab_err = 0; cyc = 0; st_hi = '0;
    endtask

    // ready_mode: 0 = low, 1 = high, 2 = random per cycle
    task automatic run_cycles(input int n, input int ready_mode);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (prev_valid && !prev_acc &&
                (valid !== 1'b1 || id !== prev_id || press !== prev_press))
                stab_err++;
            if (valid === 1'b1) valid_cycles++;
            if (overrun === 1'b1) ovr_cycles++;
            st_hi = st_hi | state;
            ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
            prev_acc   = (valid === 1'b1) && ready;
            prev_valid = (valid === 1'b1);
            prev_id    = id;
            prev_press = press;
            if (prev_acc) begin
                acc_id.push_back(int'(id));
                acc_press.push_back(int'(press));
                acc_cyc.push_back(cyc);
            end
            cyc++;
        end
    endtask

    // Switches in mask changed together: their events leave in cyclic order
    // starting at the round-robin pointer.
    task automatic model_expect(input logic [3:0] mask);
        int idx;
        exp_id.delete(); exp_press.delete();
        for (int k = 0; k < N_SW; k++) begin
            idx = (model_ptr + k) % N_SW;
            if (mask[idx]) begin
                exp_id.push_back(idx);
                exp_press.push_back(int'(model_level[idx]));
            end
        end
        if (exp_id.size() > 0) model_ptr = (exp_id[exp_id.size()-1] + 1) % N_SW;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sw = '0; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0; model_level = '0;
        prev_valid = 1'b0; prev_acc = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sw = 4'($urandom);
            if ({state, valid, id, press, overrun} !== 9'd0) bad++;
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++; $display("FAIL reset_outputs: %0d cycles nonzero, expected 0", bad);
        end
        sw = '0; rst_n = 1'b1;
        clear_obs();
        run_cycles(100, 1);
        vec_cnt++;
        if (valid_cycles != 0 || ovr_cycles != 0 || st_hi != 0) begin
            err_cnt++;
            $display("FAIL reset_idle: valid=%0d overrun=%0d state=%h, expected 0 0 0",
                     valid_cycles, ovr_cycles, st_hi);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        int lat;
        for (int ph = 0; ph < 2; ph++) begin
            ready = 1'b1;
            @(negedge clk);
            sw[2] = (ph == 0);
            lat = 0;
            while (state[2] !== (ph == 0) && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            vec_cnt++;
            if (lat < 11 || lat > 14) begin
                err_cnt++; $display("FAIL latency_%0d: %0d cycles, expected 11..14", ph, lat);
            end
            clear_obs();
            run_cycles(20, 1);
            vec_cnt++;
            if (acc_id.size() != 1 || valid_cycles != 1) begin
                err_cnt++;
                $display("FAIL clean_count_%0d: events=%0d valid_cycles=%0d, expected 1 1",
                         ph, acc_id.size(), valid_cycles);
            end else begin
                vec_cnt++;
                if (acc_id[0] != 2 || acc_press[0] != (ph == 0 ? 1 : 0)) begin
                    err_cnt++;
                    $display("FAIL clean_event_%0d: id=%0d press=%0d, expected 2 %0d",
                             ph, acc_id[0], acc_press[0], (ph == 0 ? 1 : 0));
                end
            end
            $display("clean phase %0d: latency %0d, %0d event(s)", ph, lat, acc_id.size());
        end
    endtask

    task automatic test_bounce();
        clear_obs();
        for (int t = 0; t < 12; t++) begin
            sw[1] = ~sw[1];
            run_cycles(5, 1);
        end
        sw[1] = 1'b0;
        run_cycles(40, 1);
        vec_cnt++;
        if (st_hi[1] !== 1'b0 || valid_cycles != 0) begin
            err_cnt++;
            $display("FAIL bounce: state1_seen=%0b valid_cycles=%0d, expected 0 0",
                     st_hi[1], valid_cycles);
        end
        $display("test_bounce done");
    endtask

    task automatic test_arbitration();
        int w;
        logic [3:0] masks [3];
        masks[0] = 4'b1011; masks[1] = 4'b1011; masks[2] = 4'b1001;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            model_level = model_level ^ masks[r];
            sw = model_level;
            model_expect(masks[r]);
            if (r == 0) begin
                w = 0;
                while (valid !== 1'b1 && w < 40) begin run_cycles(1, 0); w++; end
                clear_obs();
                run_cycles(20, 0);
                vec_cnt++;
                if (valid_cycles != 20 || stab_err != 0 || id !== 2'd0 || press !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL arb_stall: valid_cycles=%0d unstable=%0d id=%0d press=%0b, expected 20 0 0 1",
                             valid_cycles, stab_err, id, press);
                end
            end
            clear_obs();
            run_cycles(40, 1);
            vec_cnt++;
            if (acc_id.size() != exp_id.size()) begin
                err_cnt++;
                $display("FAIL arb_count_%0d: %0d events, expected %0d", r, acc_id.size(), exp_id.size());
            end
            for (int k = 0; k < exp_id.size() && k < acc_id.size(); k++) begin
                vec_cnt++;
                if (acc_id[k] != exp_id[k] || acc_press[k] != exp_press[k]) begin
                    err_cnt++;
                    $display("FAIL arb_event_%0d_%0d: id=%0d press=%0d, expected %0d %0d",
                             r, k, acc_id[k], acc_press[k], exp_id[k], exp_press[k]);
                end
                if (k > 0) begin
                    vec_cnt++;
                    if (acc_cyc[k] - acc_cyc[k-1] != 2) begin
                        err_cnt++;
                        $display("FAIL arb_gap_%0d_%0d: spacing %0d, expected 2",
                                 r, k, acc_cyc[k] - acc_cyc[k-1]);
                    end
                end
            end
            $display("arbitration round %0d: %0d events", r, acc_id.size());
        end
    endtask

    task automatic test_random_rr();
        logic [3:0] mask;
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            model_level = model_level ^ mask;
            sw = model_level;
            model_expect(mask);
            clear_obs();
            run_cycles(150, 2);
            vec_cnt++;
            if (acc_id.size() != exp_id.size() || stab_err != 0 || ovr_cycles != 0) begin
                err_cnt++;
                $display("FAIL rr_round_%0d: events=%0d unstable=%0d overrun=%0d, expected %0d 0 0",
                         r, acc_id.size(), stab_err, ovr_cycles, exp_id.size());
            end
            for (int k = 0; k < exp_id.size() && k < acc_id.size(); k++) begin
                vec_cnt++;
                if (acc_id[k] != exp_id[k] || acc_press[k] != exp_press[k]) begin
                    err_cnt++;
                    $display("FAIL rr_event_%0d_%0d: id=%0d press=%0d, expected %0d %0d",
                             r, k, acc_id[k], acc_press[k], exp_id[k], exp_press[k]);
                end
            end
            $display("random round %0d: mask %b, %0d events", r, mask, acc_id.size());
        end
    endtask

    task automatic test_overrun();
        int w;
        do_reset();
        sw[0] = 1'b1;
        w = 0;
        while (valid !== 1'b1 && w < 40) begin run_cycles(1, 0); w++; end
        clear_obs();
        sw[2] = 1'b1;
        run_cycles(25, 0);
        sw[2] = 1'b0;
        run_cycles(25, 0);
        vec_cnt++;
        if (ovr_cycles != 1 || st_hi[2] !== 1'b1 || state[2] !== 1'b0 || stab_err != 0) begin
            err_cnt++;
            $display("FAIL overrun_pulse: pulses=%0d sw2_rose=%0b state2=%0b unstable=%0d, expected 1 1 0 0",
                     ovr_cycles, st_hi[2], state[2], stab_err);
        end
        clear_obs();
        run_cycles(40, 1);
        vec_cnt++;
        if (acc_id.size() != 1) begin
            err_cnt++; $display("FAIL overrun_count: %0d events, expected 1", acc_id.size());
        end else begin
            vec_cnt++;
            if (acc_id[0] != 0 || acc_press[0] != 1) begin
                err_cnt++;
                $display("FAIL overrun_event: id=%0d press=%0d, expected 0 1", acc_id[0], acc_press[0]);
            end
        end
        $display("test_overrun: %0d event(s) after release", acc_id.size());
    endtask

    task automatic test_async_reset();
        int w;
        do_reset();
        sw[1] = 1'b1;
        w = 0;
        while (valid !== 1'b1 && w < 40) begin run_cycles(1, 0); w++; end
        vec_cnt++;
        if (valid !== 1'b1 || id !== 2'd1 || state[1] !== 1'b1) begin
            err_cnt++;
            $display("FAIL async_pre: valid=%0b id=%0d state1=%0b, expected 1 1 1", valid, id, state[1]);
        end
        #2 rst_n = 1'b0;
        sw = '0;
        #1;
        vec_cnt++;
        if (valid !== 1'b0 || id !== 2'd0 || state !== 4'd0) begin
            err_cnt++;
            $display("FAIL async_clear: valid=%0b id=%0d state=%h, expected 0 0 0", valid, id, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_valid = 1'b0; prev_acc = 1'b0;
        clear_obs();
        run_cycles(60, 1);
        vec_cnt++;
        if (valid_cycles != 0) begin
            err_cnt++; $display("FAIL async_stale: %0d valid cycles, expected 0", valid_cycles);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_clean_press();
        test_bounce();
        test_arbitration();
        test_random_rr();
        test_overrun();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
